// File: rtl/mcpu_prog_loader.sv
// mcpu_prog_loader
//   Front-end loader for the MCPU. On start it zeroes the whole RAM one word
//   per cycle, streams a program into it over a valid/ready word interface,
//   then lets the CPU run for a fixed number of cycles and reports completion.
//   Every output is registered.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle request to begin clear/load/run (honoured in idle/done)
//   run_cycles  CPU cycles to run, captured when start is accepted
//   in_valid    in_data/in_last are valid
//   in_ready    loader accepts a word this cycle (high only while loading)
//   in_data     program word
//   in_last     marks the final program word
//   mem_we      RAM write enable
//   mem_addr    RAM write address
//   mem_wdata   RAM write data
//   cpu_reset   active-high reset to the MCPU
//   cpu_en      MCPU clock enable
//   busy        high from accepted start until done
//   done        level, high once the sequence has finished
//   error       program filled the RAM without in_last
//   load_count  number of words written during the load phase
//   checksum    sum of loaded words, wrapping
module mcpu_prog_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int CYC_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CYC_SIZE-1:0]  run_cycles,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   load_count,
  output logic [WORD_SIZE-1:0] checksum
);

  localparam int MEM_DEPTH = 2**ADDR_SIZE;

  // S_FLUSH is the cycle that carries the final load write; the CPU is only
  // released after that write has landed in the RAM.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_RUN, S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [CYC_SIZE-1:0]  run_cycles_reg, run_cycles_next;
  logic [CYC_SIZE-1:0]  run_cnt_reg, run_cnt_next;
  logic                 mem_we_reg, mem_we_next;
  logic [ADDR_SIZE-1:0] mem_addr_reg, mem_addr_next;
  logic [WORD_SIZE-1:0] mem_wdata_reg, mem_wdata_next;
  logic                 cpu_reset_reg, cpu_reset_next;
  logic                 cpu_en_reg, cpu_en_next;
  logic                 in_ready_reg, in_ready_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 error_reg, error_next;
  logic [ADDR_SIZE:0]   load_count_reg, load_count_next;
  logic [WORD_SIZE-1:0] checksum_reg, checksum_next;

  logic accept;
  logic start_ok;
  logic full_word;   // the word being accepted is the last one the RAM can hold
  logic run_last;

  // in_ready_reg is high exactly while in S_LOAD, so it doubles as the state gate.
  assign accept    = in_valid && in_ready_reg;
  assign start_ok  = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign full_word = (load_count_reg == (ADDR_SIZE+1)'(MEM_DEPTH - 1));
  assign run_last  = (run_cnt_reg == run_cycles_reg - 1'b1);

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      run_cycles_reg <= '0;
      run_cnt_reg    <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_reset_reg  <= 1'b1;
      cpu_en_reg     <= 1'b0;
      in_ready_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      load_count_reg <= '0;
      checksum_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      run_cycles_reg <= run_cycles_next;
      run_cnt_reg    <= run_cnt_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cpu_reset_reg  <= cpu_reset_next;
      cpu_en_reg     <= cpu_en_next;
      in_ready_reg   <= in_ready_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      load_count_reg <= load_count_next;
      checksum_reg   <= checksum_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_CLEAR;
      S_CLEAR:        if (mem_addr_reg == '1) state_next = S_LOAD;
      S_LOAD:         if (accept && (in_last || full_word)) state_next = S_FLUSH;
      S_FLUSH:        state_next = (error_reg || run_cycles_reg == '0) ? S_DONE : S_RUN;
      S_RUN:          if (run_last) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    run_cycles_next = run_cycles_reg;
    run_cnt_next    = run_cnt_reg;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cpu_reset_next  = cpu_reset_reg;
    load_count_next = load_count_reg;
    checksum_next   = checksum_reg;
    error_next      = error_reg;
    in_ready_next   = (state_next == S_LOAD);
    busy_next       = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next       = (state_next == S_DONE);
    cpu_en_next     = (state_next == S_RUN);

    if (start_ok) begin
      // First clear write goes out on the cycle right after start.
      run_cycles_next = run_cycles;
      load_count_next = '0;
      checksum_next   = '0;
      error_next      = 1'b0;
      cpu_reset_next  = 1'b1;
      mem_we_next     = 1'b1;
      mem_addr_next   = '0;
      mem_wdata_next  = '0;
    end

    case (state_reg)
      S_CLEAR: begin
        if (mem_addr_reg != '1) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = mem_addr_reg + 1'b1;
          mem_wdata_next = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_next     = 1'b1;
          mem_addr_next   = load_count_reg[ADDR_SIZE-1:0];
          mem_wdata_next  = in_data;
          load_count_next = load_count_reg + 1'b1;
          checksum_next   = checksum_reg + in_data;
          if (full_word && !in_last) error_next = 1'b1;
        end
      end
      S_FLUSH: begin
        run_cnt_next = '0;
        // cpu_reset only drops when the CPU actually gets to run; it then
        // stays low through DONE so the CPU state remains inspectable.
        if (state_next == S_RUN) cpu_reset_next = 1'b0;
      end
      S_RUN: begin
        run_cnt_next = run_cnt_reg + 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign cpu_en     = cpu_en_reg;
  assign in_ready   = in_ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign load_count = load_count_reg;
  assign checksum   = checksum_reg;

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Testbench for mcpu_prog_loader.
// Each job is described as a program (words, per-word idle gaps, last flag,
// run length). From that description the expected output of every cycle is
// derived as a timeline counted from the start edge: 256 clear writes, load
// writes at the accept edges, one flush cycle, run_cycles enabled cycles,
// then done.
module tb_mcpu_prog_loader;

  localparam int W     = 16;
  localparam int A     = 8;
  localparam int C     = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [C-1:0]  run_cycles = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [A-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          cpu_reset, cpu_en, busy, done, error;
  logic [A:0]    load_count;
  logic [W-1:0]  checksum;

  always #5 clk = ~clk;

  mcpu_prog_loader #(.WORD_SIZE(W), .ADDR_SIZE(A), .CYC_SIZE(C)) dut (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy), .done(done), .error(error),
    .load_count(load_count), .checksum(checksum)
  );

  int vectors = 0;
  int miscompares = 0;

  // pending job (written by the stimulus before start)
  int           p_n, p_rc;
  bit           p_last;
  int           p_e[DEPTH];     // edge index (from start edge) at which word i is accepted
  logic [W-1:0] p_w[DEPTH];

  // job captured at the accepted start edge
  bit           m_valid = 1'b0;
  int           k = 0;          // cycle index since the start edge
  int           m_n = 0, m_rc = 0;
  bit           m_last = 1'b0;
  int           m_e[DEPTH];
  logic [W-1:0] m_w[DEPTH];
  int           en_cnt = 0;

  // RAM image built from the write port
  logic         preload = 1'b0;
  logic [W-1:0] ram[DEPTH];

  function automatic int m_done_cycle();
    int  e_last;
    bit  over;
    if (m_n < 1) return 0;
    e_last = m_e[m_n-1];
    over   = (m_n == DEPTH) && !m_last;
    return (!over && m_rc != 0) ? e_last + m_rc + 1 : e_last + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      k       <= 0;
    end else if (start && (!m_valid || k >= m_done_cycle())) begin
      m_valid <= 1'b1;
      k       <= 0;
      m_n     <= p_n;
      m_rc    <= p_rc;
      m_last  <= p_last;
      for (int i = 0; i < DEPTH; i++) begin
        m_e[i] <= p_e[i];
        m_w[i] <= p_w[i];
      end
    end else begin
      k <= k + 1;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 16'hFFFF;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h, want %0h (t=%0t k=%0d)", name, act, exp_v, $time, k);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_cpu_en"}, cpu_en, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_load_count"}, load_count, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // Per-cycle comparison against the job timeline.
  task automatic compare_cycle();
    int           e_last, ds, lc, ad;
    logic [W-1:0] cs, wd;
    bit           we, over, runs;
    if (!reset) return;
    if (!m_valid) begin
      chk_idle("idle");
      return;
    end
    e_last = m_e[m_n-1];
    over   = (m_n == DEPTH) && !m_last;
    runs   = !over && (m_rc != 0);
    ds     = m_done_cycle();
    lc = 0; cs = '0; we = 1'b0; ad = 0; wd = '0;
    if (k < DEPTH) begin
      we = 1'b1;
      ad = k;
    end
    for (int i = 0; i < m_n; i++) begin
      if (m_e[i] <= k) begin
        lc++;
        cs = cs + m_w[i];
      end
      if (m_e[i] == k) begin
        we = 1'b1;
        ad = i;
        wd = m_w[i];
      end
    end
    if (k == 0) en_cnt = 0;
    if (cpu_en) en_cnt++;
    chk("mem_we", mem_we, we);
    if (we) begin
      chk("mem_addr", mem_addr, ad);
      chk("mem_wdata", mem_wdata, wd);
    end
    chk("in_ready", in_ready, k >= DEPTH && k < e_last);
    chk("load_count", load_count, lc);
    chk("checksum", checksum, cs);
    chk("error", error, over && k >= e_last);
    chk("cpu_en", cpu_en, runs && k > e_last && k <= e_last + m_rc);
    chk("cpu_reset", cpu_reset, !(runs && k > e_last));
    chk("done", done, k >= ds);
    chk("busy", busy, k < ds);
  endtask

  // Compare at the negedge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #2;
  endtask

  // gap < 0 picks a random 0..3 idle cycles before each word.
  // rst_after > 0 drops reset once that many words have been accepted.
  task automatic run_job(input int n, input bit last, input int rc, input int gap,
                         input int rst_after, input bit poke);
    int acc, e_last, ds, widx;
    bit over;
    p_n = n; p_last = last; p_rc = rc;
    acc = DEPTH;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      acc = acc + 1 + g;
      p_e[i] = acc;
    end
    e_last = p_e[n-1];
    over   = (n == DEPTH) && !last;
    ds     = (!over && rc != 0) ? e_last + rc + 1 : e_last + 1;
    // start together with a valid word: the word must not be taken
    start = 1'b1; run_cycles = C'(rc);
    in_valid = 1'b1; in_data = W'($urandom); in_last = 1'b1;
    step();
    for (int guard = 0; guard < 6000; guard++) begin
      if (k >= ds + 2) break;
      start = (poke && (k == 100 || k == ds - 2)) ? 1'b1 : 1'b0;
      widx = -1;
      for (int i = 0; i < n; i++) if (p_e[i] == k + 1) widx = i;
      in_data = W'($urandom);
      in_last = 1'($urandom);
      if (widx >= 0) begin
        in_valid = 1'b1;
        in_data  = p_w[widx];
        in_last  = last && (widx == n - 1);
      end else if (k >= DEPTH && k < e_last) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom);
      end
      if (rst_after > 0 && k == p_e[rst_after-1] + 1) begin
        reset = 1'b0;
        #1;
        chk_idle("async_rst");
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        return;
      end
      step();
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) p_w[i] = W'($urandom);
  endtask

  initial begin
    int bad;
    preload = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    #2 preload = 1'b0;
    chk_idle("reset");
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) step();

    // 1: clear over a preloaded RAM, one-word program
    p_w[0] = 16'hBEEF;
    run_job(1, 1'b1, 3, 0, 0, 1'b0);
    bad = 0;
    for (int i = 1; i < DEPTH; i++) if (ram[i] !== 16'h0000) bad++;
    chk("clear_nonzero_words", bad, 0);
    chk("clear_ram0", ram[0], 16'hBEEF);
    chk("j1_count", load_count, 1);
    chk("j1_en_cycles", en_cnt, 3);

    // 2/3: fixed three-word program without and with backpressure gaps
    for (int g = 0; g <= 2; g += 2) begin
      p_w[0] = 16'h1234; p_w[1] = 16'h0001; p_w[2] = 16'hFFFF;
      run_job(3, 1'b1, 5, g, 0, 1'b0);
      chk("three_count", load_count, 3);
      chk("three_checksum", checksum, 16'h1234);
      chk("three_ram0", ram[0], 16'h1234);
      chk("three_ram1", ram[1], 16'h0001);
      chk("three_ram2", ram[2], 16'hFFFF);
      chk("three_ram3", ram[3], 16'h0000);
      chk("three_done", done, 1);
    end

    // 4: 16-word program, 57 run cycles, start pokes while busy
    rand_words(16);
    run_job(16, 1'b1, 57, -1, 0, 1'b1);
    chk("run57_en_cycles", en_cnt, 57);
    chk("run57_done", done, 1);
    chk("run57_cpu_reset", cpu_reset, 0);

    // 5: overflow
    rand_words(DEPTH);
    run_job(DEPTH, 1'b0, 9, -1, 0, 1'b0);
    chk("ovf_error", error, 1);
    chk("ovf_count", load_count, 256);
    chk("ovf_en_cycles", en_cnt, 0);
    chk("ovf_cpu_reset", cpu_reset, 1);
    chk("ovf_done", done, 1);

    // 6: full RAM with in_last on the final word
    rand_words(DEPTH);
    run_job(DEPTH, 1'b1, 4, 0, 0, 1'b0);
    chk("full_error", error, 0);
    chk("full_count", load_count, 256);
    chk("full_en_cycles", en_cnt, 4);

    // 7: run_cycles = 0
    rand_words(5);
    run_job(5, 1'b1, 0, 1, 0, 1'b0);
    chk("rc0_en_cycles", en_cnt, 0);
    chk("rc0_cpu_reset", cpu_reset, 1);
    chk("rc0_done", done, 1);

    // 8: reset after five words, then a fresh job
    rand_words(20);
    run_job(20, 1'b1, 6, -1, 5, 1'b0);
    repeat (3) step();
    rand_words(7);
    run_job(7, 1'b1, 11, -1, 0, 1'b0);
    chk("after_rst_count", load_count, 7);
    chk("after_rst_en_cycles", en_cnt, 11);

    // random jobs
    for (int j = 0; j < 4; j++) begin
      int n;
      n = int'($urandom_range(40, 1));
      rand_words(n);
      run_job(n, 1'b1, int'($urandom_range(30, 0)), -1, 0, 1'b0);
      repeat (int'($urandom_range(3, 0))) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
